muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide execution unit for the RV32M/RV64M extension; the next generation of the ALU operation-control path.
- Sits beside the single-cycle ALU. It is selected when the decoder sees an R-type instruction with funct7 = 0000001 and receives funct3 directly.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
- Uses valid/ready handshakes on both the command and the result side, plus a flush for pipeline squash.

---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative RV32M/RV64M multiply/divide unit, one bit per cycle
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_op;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_result;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_is_div;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_div0;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic              w_last;
  logic              w_mul;
  logic [XLEN:0]     w_add_a;
  logic [XLEN:0]     w_add_b;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_mul_sum;
  logic              w_ge;
  logic [XLEN-1:0]   w_hi_nxt;
  logic [XLEN-1:0]   w_lo_nxt;
  logic [XLEN-1:0]   w_hi_neg;
  logic [XLEN-1:0]   w_fix;

  assign cmd_ready = (r_state == S_IDLE) && !flush;
  assign rsp_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;

  assign w_accept   = cmd_valid && cmd_ready;
  assign w_is_div   = funct3[2];
  assign w_a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
  assign w_b_signed = w_a_signed && (funct3 != 3'b010);
  assign w_a_neg    = w_a_signed && op_a[XLEN-1];
  assign w_b_neg    = w_b_signed && op_b[XLEN-1];
  assign w_mag_a    = w_a_neg ? -op_a : op_a;
  assign w_mag_b    = w_b_neg ? -op_b : op_b;

  assign w_div0        = w_is_div && (op_b == '0);
  assign w_ovf         = w_is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  assign w_special     = w_div0 || w_ovf;
  assign w_special_res = w_div0 ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);

  assign w_last = (r_cnt == CNT_W'(XLEN-1));

  // Single shared adder: multiply adds the multiplicand to the high half,
  // divide subtracts the divisor from the shifted partial remainder.
  assign w_mul     = !r_op[2];
  assign w_add_a   = w_mul ? {1'b0, r_hi} : {r_hi, r_lo[XLEN-1]};
  assign w_add_b   = {1'b0, r_b};
  assign w_sum     = w_add_a + (w_mul ? w_add_b : ~w_add_b) + {{XLEN{1'b0}}, !w_mul};
  assign w_mul_sum = r_lo[0] ? w_sum : w_add_a;
  // A set top bit of the shifted remainder always exceeds the divisor.
  assign w_ge      = w_add_a[XLEN] || !w_sum[XLEN];

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (w_mul) begin
      w_hi_nxt = w_mul_sum[XLEN:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end else begin
      w_hi_nxt = w_ge ? w_sum[XLEN-1:0] : w_add_a[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
    end
  end

  // Upper half of the negated 2*XLEN product borrows only when the low half is zero.
  assign w_hi_neg = ~w_hi_nxt + {{(XLEN-1){1'b0}}, (w_lo_nxt == '0)};

  always_comb begin
    w_fix = w_lo_nxt;
    case (r_op)
      3'b000, 3'b100, 3'b101: w_fix = r_neg_q ? -w_lo_nxt : w_lo_nxt;
      3'b001, 3'b010, 3'b011: w_fix = r_neg_q ? w_hi_neg : w_hi_nxt;
      default:                w_fix = r_neg_r ? -w_hi_nxt : w_hi_nxt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= funct3;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= w_is_div ? w_mag_a : w_mag_b;
            r_b     <= w_is_div ? w_mag_b : w_mag_a;
            if (w_special) r_result <= w_special_res;
          end
        end
        S_CALC: begin
          r_hi <= w_hi_nxt;
          r_lo <= w_lo_nxt;
          if (w_last) r_result <= w_fix;
          else        r_cnt    <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32): directed plan vectors plus
// randomised operations checked against a behavioural reference.
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] result;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] p;
    logic        [63:0] up;
    logic signed [31:0] sq;
    logic        [31:0] r;
    logic               ovf;
    sa  = $signed({{32{a[31]}}, a});
    sb  = $signed({{32{b[31]}}, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * $signed({32'b0, b}); r = p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
      3'd4: begin
        if (b == 0)   r = 32'hFFFF_FFFF;
        else if (ovf) r = a;
        else begin sq = $signed(a) / $signed(b); r = sq; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0)   r = a;
        else if (ovf) r = '0;
        else begin sq = $signed(a) % $signed(b); r = sq; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issue one command, measure latency, optionally stall the response, then retire it.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input int hold);
    int          n;
    logic [31:0] want;
    @(negedge clk);
    cmd_valid = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(posedge clk);
    exp_q.push_back(exp);
    #1 cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, lat);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk("result", result, want);
    last_res = want;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9;
      @(posedge clk); #1;
      chk("hold_result", result, want);
      chk("hold_cmd_ready", cmd_ready, 1'b0);
      chk("hold_valid", rsp_valid, 1'b1);
    end
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("retire_valid", rsp_valid, 1'b0);
    chk("retire_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Start a DIV, then abort it after 15 iterations with flush or reset.
  task automatic abort_op(input logic use_reset);
    int hits;
    @(negedge clk);
    cmd_valid = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    if (use_reset) rst_n = 1'b0;
    else begin
      flush = 1'b1; cmd_valid = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5;
      #1 chk("flush_cmd_ready", cmd_ready, 1'b0);
    end
    @(posedge clk); #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", rsp_valid, 1'b0);
    chk("abort_result", result, use_reset ? 32'd0 : last_res);
    @(negedge clk);
    rst_n = 1'b1; flush = 1'b0; cmd_valid = 1'b0;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) hits++;
    end
    chk("abort_no_rsp", hits, 0);
    run_op(3'b000, 32'd3, 32'd4, 32'd12, 33, 0);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        spec;
    rst_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op(3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op(3'b010, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF, 33, 0);
    run_op(3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 0);
    run_op(3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op(3'b101, 32'd100,        32'd7,         32'd14,        33, 0);
    run_op(3'b111, 32'd100,        32'd7,         32'd2,         33, 0);
    run_op(3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op(3'b110, 32'd5,          32'd0,         32'd5,         1,  0);
    run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
    run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0);
    run_op(3'b000, 32'd123,        32'd456,       32'd56088,     33, 10);

    for (int i = 0; i < 12; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      if (i % 3 == 1) b = b >> $urandom_range(0, 28);
      spec = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      run_op(f, a, b, ref_md(f, a, b), spec ? 1 : 33, 0);
    end

    abort_op(1'b0);
    abort_op(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
